// File: rtl/ahb_bridge_arbiter_if.sv
// Request/grant bundle between the AHB masters, the bridge hready and the arbiter.
// "slave" is the arbiter side; "master" is the side that drives requests and hready.
interface ahb_bridge_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int MW          = 2
);
    logic [NUM_MASTERS-1:0] hbusreq;
    logic [NUM_MASTERS-1:0] hlock;
    logic [1:0]             htrans;
    logic                   hready;
    logic [NUM_MASTERS-1:0] hgrant;
    logic [MW-1:0]          hmaster;
    logic                   hmastlock;

    modport master (
        output hbusreq, hlock, htrans, hready,
        input  hgrant, hmaster, hmastlock
    );

    modport slave (
        input  hbusreq, hlock, htrans, hready,
        output hgrant, hmaster, hmastlock
    );
endinterface

// File: rtl/ahb_bridge_arbiter.sv
// Round-robin arbiter sharing the AHB-to-APB bridge port; grants move only on hready=1 edges.
// Optional burst-length pre-emption is enabled by defining ARB_TIMEOUT_EN.
module ahb_bridge_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int MAX_BURST   = 8,
    parameter int MW          = 2
) (
    input  logic                 hclk,
    input  logic                 hresetn,
    ahb_bridge_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_PARK = 2'd0,
        ST_OWN  = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    state_t                 state_q, state_d;
    logic [MW-1:0]          master_q, master_d;
    logic [MW-1:0]          rr_q;
    logic [7:0]             beat_q;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic                   lock_q, lock_d;

    logic [NUM_MASTERS-1:0] owner_mask;
    logic [MW:0]            pick_all, pick_other;
    logic                   owner_req, owner_lock, lock_release, preempt;
    logic                   grant_change;

    // Returns {found, index}: first requester after ptr, wrapping, with ptr itself scanned last.
    function automatic logic [MW:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                            input logic [MW-1:0]          ptr);
        logic [MW:0]   res;
        logic [MW-1:0] idx;
        res = '0;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            idx = MW'((int'(ptr) + i) % NUM_MASTERS);
            if (req[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign owner_mask   = NUM_MASTERS'(1) << master_q;
    assign pick_all     = rr_pick(bus.hbusreq, rr_q);
    assign pick_other   = rr_pick(bus.hbusreq & ~owner_mask, rr_q);
    assign owner_req    = bus.hbusreq[master_q];
    assign owner_lock   = bus.hlock[master_q];
    assign lock_release = !owner_lock && (bus.htrans == HTRANS_IDLE);

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

    // Pre-empt only at a burst boundary so a SEQ run is never split.
    assign preempt = (state_q == ST_OWN) && (beat_q >= BURST_LIMIT) && pick_other[MW] &&
                     ((bus.htrans == HTRANS_NONSEQ) || (bus.htrans == HTRANS_IDLE));
`else
    localparam logic [7:0] unused_burst_limit = 8'(MAX_BURST);

    assign preempt = 1'b0;
`endif

    // Next-state decision; it only takes effect on an hready=1 edge.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        master_d = master_q;
        unique case (state_q)
            ST_PARK: begin
                if (pick_all[MW]) begin
                    master_d = pick_all[MW-1:0];
                    state_d  = bus.hlock[pick_all[MW-1:0]] ? ST_LOCK : ST_OWN;
                end
            end
            ST_OWN, ST_LOCK: begin
                if (state_q == ST_LOCK && !lock_release) begin
                    state_d = ST_LOCK;
                end else if (preempt) begin
                    master_d = pick_other[MW-1:0];
                    state_d  = bus.hlock[pick_other[MW-1:0]] ? ST_LOCK : ST_OWN;
                end else if (owner_req) begin
                    state_d = owner_lock ? ST_LOCK : ST_OWN;
                end else if (pick_other[MW]) begin
                    master_d = pick_other[MW-1:0];
                    state_d  = bus.hlock[pick_other[MW-1:0]] ? ST_LOCK : ST_OWN;
                end else begin
                    master_d = '0;
                    state_d  = ST_PARK;
                end
            end
            default: begin
                master_d = '0;
                state_d  = ST_PARK;
            end
        endcase
    end

    // Leaving park counts as a new ownership even when master 0 keeps the bus.
    assign grant_change = (master_d != master_q) ||
                          ((state_q == ST_PARK) && (state_d != ST_PARK));

    always_comb begin
        grant_d = NUM_MASTERS'(1) << master_d;
        lock_d  = (state_d == ST_LOCK);
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q  <= ST_PARK;
            master_q <= '0;
            rr_q     <= '0;
            beat_q   <= '0;
            grant_q  <= NUM_MASTERS'(1);
            lock_q   <= 1'b0;
        end else if (bus.hready) begin
            state_q  <= state_d;
            master_q <= master_d;
            grant_q  <= grant_d;
            lock_q   <= lock_d;
            if (grant_change) begin
                rr_q   <= master_d;
                beat_q <= '0;
            end else if (bus.htrans[1] && (beat_q != 8'hFF)) begin
                beat_q <= beat_q + 8'd1;
            end
        end
    end

    assign bus.hgrant    = grant_q;
    assign bus.hmaster   = master_q;
    assign bus.hmastlock = lock_q;

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Directed bench for ahb_bridge_arbiter (4 masters, MAX_BURST=8); covers both ARB_TIMEOUT_EN builds.
module tb_ahb_bridge_arbiter;

    logic hclk = 1'b0;
    logic hresetn;
    int   tests = 0;
    int   fails = 0;

    ahb_bridge_arbiter_if #(.NUM_MASTERS(4), .MW(2)) bus ();

    ahb_bridge_arbiter #(.NUM_MASTERS(4), .MAX_BURST(8), .MW(2)) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus)
    );

    always #5 hclk = ~hclk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic expect_bus(input string tag, input logic [3:0] grant, input logic [1:0] master,
                              input logic lock);
        check({tag, "_hgrant"},    32'(bus.hgrant),    32'(grant));
        check({tag, "_hmaster"},   32'(bus.hmaster),   32'(master));
        check({tag, "_hmastlock"}, 32'(bus.hmastlock), 32'(lock));
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge hclk);
        #1;
    endtask

    initial begin
        hresetn     = 1'b0;
        bus.hbusreq = 4'b0000;
        bus.hlock   = 4'b0000;
        bus.htrans  = 2'b00;
        bus.hready  = 1'b1;

        // Reset values
        #12;
        expect_bus("reset", 4'b0001, 2'd0, 1'b0);
        @(negedge hclk);
        hresetn = 1'b1;
        step(1);
        expect_bus("park_idle", 4'b0001, 2'd0, 1'b0);

        // Round-robin: all request, owner drops one cycle per grant -> 1,2,3,0,1
        bus.hbusreq = 4'b1111;
        step(1);
        expect_bus("rr_1", 4'b0010, 2'd1, 1'b0);
        bus.hbusreq = 4'b1101;
        step(1);
        expect_bus("rr_2", 4'b0100, 2'd2, 1'b0);
        bus.hbusreq = 4'b1011;
        step(1);
        expect_bus("rr_3", 4'b1000, 2'd3, 1'b0);
        bus.hbusreq = 4'b0111;
        step(1);
        expect_bus("rr_0", 4'b0001, 2'd0, 1'b0);
        bus.hbusreq = 4'b1110;
        step(1);
        expect_bus("rr_1b", 4'b0010, 2'd1, 1'b0);

        // Wait states: owner 1 drops while hready=0 -> grant frozen
        bus.hready  = 1'b0;
        bus.hbusreq = 4'b1101;
        for (int i = 0; i < 3; i++) begin
            step(1);
            expect_bus("wait_hold", 4'b0010, 2'd1, 1'b0);
        end
        bus.hready = 1'b1;
        step(1);
        expect_bus("wait_release", 4'b0100, 2'd2, 1'b0);

        // Back to park, then master 2 wins alone with lock
        bus.hbusreq = 4'b0000;
        step(1);
        expect_bus("park_again", 4'b0001, 2'd0, 1'b0);
        bus.hbusreq = 4'b0100;
        bus.hlock   = 4'b0100;
        step(1);
        expect_bus("lock_win", 4'b0100, 2'd2, 1'b1);
        bus.hbusreq = 4'b0111;
        bus.htrans  = 2'b10;
        step(2);
        expect_bus("lock_others", 4'b0100, 2'd2, 1'b1);
        bus.hbusreq = 4'b0011;
        step(1);
        expect_bus("lock_reqdrop", 4'b0100, 2'd2, 1'b1);
        bus.hlock  = 4'b0000;
        bus.htrans = 2'b11;
        step(1);
        expect_bus("lock_seq", 4'b0100, 2'd2, 1'b1);
        bus.htrans = 2'b00;
        step(1);
        expect_bus("lock_exit", 4'b0001, 2'd0, 1'b0);

        // Park: master 3 owns, everyone drops, master 3 returns
        bus.hbusreq = 4'b1000;
        step(1);
        expect_bus("own_3", 4'b1000, 2'd3, 1'b0);
        bus.hbusreq = 4'b0000;
        step(1);
        expect_bus("park_3drop", 4'b0001, 2'd0, 1'b0);
        step(1);
        expect_bus("park_stay", 4'b0001, 2'd0, 1'b0);
        bus.hbusreq = 4'b1000;
        step(1);
        expect_bus("park_regrant", 4'b1000, 2'd3, 1'b0);

        // Burst limit: master 1 streams, master 2 waits
        bus.hbusreq = 4'b0010;
        step(1);
        expect_bus("burst_own1", 4'b0010, 2'd1, 1'b0);
        bus.hbusreq = 4'b0110;
        bus.htrans  = 2'b10;
        step(1);
        bus.htrans = 2'b11;
        step(7);
        expect_bus("burst_8beats", 4'b0010, 2'd1, 1'b0);
        step(2);
        expect_bus("burst_seq_hold", 4'b0010, 2'd1, 1'b0);
        bus.htrans = 2'b10;
        step(1);
`ifdef ARB_TIMEOUT_EN
        expect_bus("burst_preempt", 4'b0100, 2'd2, 1'b0);
`else
        expect_bus("burst_no_preempt", 4'b0010, 2'd1, 1'b0);
        bus.htrans = 2'b00;
        step(1);
        expect_bus("burst_no_preempt_idle", 4'b0010, 2'd1, 1'b0);
`endif

        // Asynchronous reset mid-burst
        bus.htrans = 2'b11;
        @(posedge hclk);
        #2;
        hresetn = 1'b0;
        #1;
        expect_bus("async_reset", 4'b0001, 2'd0, 1'b0);
        step(2);
        expect_bus("reset_held", 4'b0001, 2'd0, 1'b0);
        @(negedge hclk);
        hresetn    = 1'b1;
        bus.htrans = 2'b00;
        step(1);
        expect_bus("post_reset", 4'b0010, 2'd1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
